// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: loads a WIDTH-bit pattern word and drives it bit-serially,
// MSB first, on x, repeating it repeat_n extra times back to back.
// Optional build macro PATTERN_LFSR_EN adds a prbs_mode input that replaces the
// held word with a Fibonacci LFSR seeded from data_in.
//
// state   | meaning
// S_IDLE  | waiting for start; outputs quiet
// S_SHIFT | one pattern bit per cycle on x, valid/busy high
// S_DONE  | single-cycle done pulse, start ignored
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [REP_W-1:0] repeat_n,
`ifdef PATTERN_LFSR_EN
  input  logic             prbs_mode,
`endif
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

`ifdef PATTERN_LFSR_EN
  // Maximal-length tap masks (bit k-1 set for polynomial term x^k), shift-left form.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:  return 32'h0000_0003;
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  logic prbs_q, prbs_d;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] lfsr_next;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef PATTERN_LFSR_EN
  // LFSR seed substitution and one-step advance of the running state.
  always_comb begin
    seed      = (data_in == '0) ? '1 : data_in;
    lfsr_next = lfsr_step(shift_q);
  end
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    x_d       = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef PATTERN_LFSR_EN
    prbs_d    = prbs_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hold_d    = data_in;
          rep_cnt_d = repeat_n;
          bit_cnt_d = '0;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
          // shift_q holds the bits still to be sent, left-aligned
          shift_d   = data_in << 1;
          x_d       = data_in[WIDTH-1];
`ifdef PATTERN_LFSR_EN
          prbs_d = prbs_mode;
          if (prbs_mode) begin
            // in PRBS mode shift_q is the LFSR state and x mirrors its MSB
            shift_d = seed;
            x_d     = seed[WIDTH-1];
          end
`endif
        end
      end
      S_SHIFT: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (bit_cnt_q == LAST_BIT && rep_cnt_q == '0) begin
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_DONE;
        end else if (bit_cnt_q == LAST_BIT) begin
          rep_cnt_d = rep_cnt_q - REP_W'(1);
          bit_cnt_d = '0;
          x_d       = hold_q[WIDTH-1];
          shift_d   = hold_q << 1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          x_d       = shift_q[WIDTH-1];
          shift_d   = shift_q << 1;
        end
`ifdef PATTERN_LFSR_EN
        if (prbs_q && state_d == S_SHIFT) begin
          // the LFSR free-runs across word boundaries; only timing is per-word
          shift_d = lfsr_next;
          x_d     = lfsr_next[WIDTH-1];
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      hold_q    <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      x_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PATTERN_LFSR_EN
      prbs_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PATTERN_LFSR_EN
      prbs_q    <= prbs_d;
`endif
    end
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: a driver issues starts and pushes the expected
// bit stream and done cycle into queues; a monitor pops and compares on valid/done.
`timescale 1ns/1ps
module tb_serial_pattern_gen;
  localparam int WIDTH = 8;
  localparam int REP_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [REP_W-1:0] repeat_n = '0;
`ifdef PATTERN_LFSR_EN
  logic             prbs_mode = 1'b0;
`endif
  logic x, valid, busy, done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int free_cycle = 0;

  typedef struct {
    int   cyc;
    logic b;
  } bit_t;
  bit_t bit_q[$];
  int   done_q[$];

  serial_pattern_gen #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .repeat_n (repeat_n),
`ifdef PATTERN_LFSR_EN
    .prbs_mode(prbs_mode),
`endif
    .x        (x),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a start accepted during cycle k yields its bit stream on cycles
  // k+1..k+N, done on k+N+1, and the next start is honoured from cycle k+N+2.
  task automatic accept(input logic [WIDTH-1:0] d, input int r, input logic p);
    int n;
    int s[$];
    logic [WIDTH-1:0] seed;
    n = (r + 1) * WIDTH;
    if (p) begin
      seed = (d == '0) ? 8'hFF : d;
      for (int i = 0; i < WIDTH; i++) s.push_back(int'(seed[WIDTH-1-i]));
      while (s.size() < n) begin
        int k;
        k = s.size() - 8;
        s.push_back(s[k] ^ s[k+2] ^ s[k+3] ^ s[k+4]);
      end
    end else begin
      for (int i = 0; i < n; i++) s.push_back(int'(d[WIDTH-1-(i % WIDTH)]));
    end
    for (int i = 0; i < n; i++) begin
      bit_t e;
      e.cyc = cyc + 1 + i;
      e.b   = s[i][0];
      bit_q.push_back(e);
    end
    done_q.push_back(cyc + 1 + n);
    free_cycle = cyc + n + 2;
  endtask

  task automatic drive(input logic s, input logic [WIDTH-1:0] d, input int r, input logic p);
    logic pm;
    @(posedge clk);
    #1;
    start    = s;
    data_in  = d;
    repeat_n = REP_W'(r);
`ifdef PATTERN_LFSR_EN
    prbs_mode = p;
    pm = p;
`else
    pm = 1'b0;
`endif
    if (s && cyc >= free_cycle) accept(d, r, pm);
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 2000 && cyc < free_cycle; g++)
      drive(1'b0, WIDTH'($urandom), int'($urandom_range(0, 31)), 1'b0);
    check("drain_timeout", (cyc >= free_cycle) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_x", x, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    bit_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    free_cycle = cyc;
  endtask

  // Monitor: pop an expected bit for every valid cycle and a done cycle for every pulse.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (bit_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=1 expected no bit (cycle %0d)", cyc);
      end else begin
        bit_t e;
        e = bit_q.pop_front();
        check("x_bit", x, e.b);
        check("bit_cycle", cyc, e.cyc);
      end
      check("busy_with_valid", busy, 1);
    end else begin
      check("x_quiet", x, 0);
      check("busy_quiet", busy, 0);
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("init_x", x, 0);
    check("init_valid", valid, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    reset = 1'b0;
    free_cycle = cyc;
    repeat (5) drive(1'b0, WIDTH'($urandom), 0, 1'b0);

    drive(1'b1, 8'hA6, 0, 1'b0);
    wait_idle();

    drive(1'b1, 8'h81, 2, 1'b0);
    wait_idle();

    // start held high; data_in drops to 0 whenever a start would not be accepted
    for (int i = 0; i < 20; i++)
      drive(1'b1, (cyc + 1 >= free_cycle) ? 8'hFF : 8'h00, 0, 1'b0);
    wait_idle();

    drive(1'b1, 8'hC3, 1, 1'b0);
    repeat (5) drive(1'b0, 8'h00, 0, 1'b0);
    mid_reset();
    drive(1'b1, 8'h5C, 0, 1'b0);
    wait_idle();

    drive(1'b1, 8'h3C, 31, 1'b0);
    wait_idle();

`ifdef PATTERN_LFSR_EN
    drive(1'b1, 8'h01, 31, 1'b1);
    wait_idle();
    drive(1'b1, 8'h00, 1, 1'b1);
    wait_idle();
`endif

    for (int i = 0; i < 60; i++) begin
      logic s;
      int   r;
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 2));
      drive(s, WIDTH'($urandom), r, 1'($urandom));
    end
    wait_idle();
    repeat (3) drive(1'b0, 8'h00, 0, 1'b0);

    check("bits_left", bit_q.size(), 0);
    check("dones_left", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
Transmit-side companion to the team's serial sequence-detector FSM circuits. Loads a parallel pattern word and drives it bit-serially, MSB first, on a single-bit line `x`, one bit per clock. Optionally repeats the word back to back. Used as the stimulus source feeding `x` of a detector, in benches and in on-chip self-test.

Parameters:
WIDTH, 8, pattern word length in bits (2..32)
REP_W, 4, width of repeat-count input; words sent per start = repeat_n + 1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request transmission; sampled only in IDLE
data_in  input  WIDTH  pattern word, captured when start is accepted
repeat_n  input  REP_W  extra repetitions, captured with data_in
x  output  1  serial bit out, registered
valid  output  1  high while x carries a pattern bit
busy  output  1  high from accept cycle through last bit
done  output  1  one-cycle pulse after last bit of last word

Behaviour:
- Reset (async, any state): state=IDLE; x=0, valid=0, busy=0, done=0; shift register, bit counter and repeat counter cleared.
- All outputs are registered. No combinational path from any input to any output.
- State IDLE:
  - x=0, valid=0, busy=0.
  - Edge with start=1: capture data_in into the hold register and the shift register; capture repeat_n into rep_cnt; go to SHIFT.
  - On that same edge: x<=data_in[WIDTH-1], valid<=1, busy<=1.
  - Latency: first bit visible one cycle after start is sampled.
- State SHIFT:
  - Each edge advances one bit, MSB first; bit_cnt counts 0..WIDTH-1.
  - After bit WIDTH-1 of a word with rep_cnt>0: reload the shift register from the hold register and decrement rep_cnt. The next word's MSB follows on the very next cycle (no gap, valid stays 1).
  - After bit WIDTH-1 with rep_cnt==0: go to DONE; x<=0, valid<=0.
- State DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - A start present in the DONE cycle is ignored. The earliest accepted start is the first IDLE edge.
- start while busy or in DONE: ignored. Changes to data_in and repeat_n during SHIFT have no effect (held copies are used).
- Total busy duration per start = (repeat_n+1)*WIDTH cycles. repeat_n at its maximum (2^REP_W - 1) is legal; rep_cnt never wraps.
- start held high continuously: back-to-back transfers separated by one DONE cycle plus one IDLE accept edge.
- Reset mid-transfer: aborts immediately. No done pulse; x returns to 0.

Optional Feature:
Macro `PATTERN_LFSR_EN`.
- Defined:
  - Adds input port `prbs_mode` (1 bit), sampled with start.
  - If prbs_mode=1 at accept, data_in seeds a WIDTH-bit Fibonacci LFSR; a zero seed is replaced by all-ones.
  - Instead of reloading the hold register on each word, the LFSR advances one step per bit and x is its MSB. Word/repeat/done timing is identical.
  - Taps for WIDTH=8: x^8+x^6+x^5+x^4+1. For other WIDTH, a documented maximal-length table.
- Not defined: no `prbs_mode` port, no LFSR logic; behaviour exactly as above.

Test Plan:
- Reset asserted mid-cycle with no clock edge -> x, valid, busy, done go to 0 at once. Release, start=0 for 5 cycles -> outputs stay 0.
- WIDTH=8, data_in=8'hA6, repeat_n=0, start pulsed 1 cycle -> x = 1,0,1,0,0,1,1,0 on cycles 1..8 with valid=1. done=1 on cycle 9 only; busy high cycles 1..8.
- data_in=8'h81, repeat_n=2 -> 24 contiguous valid bits, pattern 10000001 three times with no gap. Single done pulse at cycle 25.
- Start held high, data_in=8'hFF, repeat_n=0 -> second transfer's first bit appears exactly 2 cycles after the first done cycle. data_in changed to 8'h00 mid-transfer does not alter the current word.
- Reset asserted at bit 4 of a transfer -> x=0, valid=0, busy=0 immediately; no done pulse. A new start after release transmits from the MSB.
- With PATTERN_LFSR_EN, prbs_mode=1, seed 8'h01, repeat_n=31 -> 256 bits. The bit sequence matches the reference LFSR model and repeats with period 255.
